// File: rtl/controlador_criptografia.sv
// Iterative AES-128 encryption engine (FIPS-197).
// One transformation per clock: key schedule, AddRoundKey, SubBytes,
// ShiftRows and MixColumns are sequenced by a single registered FSM.
// Byte 0 of every 128-bit word sits at bits [127:120]; state byte r+4c
// is row r, column c.
module controlador_criptografia (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] chave,
  input  logic [127:0] palavra,
  output logic [127:0] cifra,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE, KEYEXP, ARK0, SB, SR, MC, ARK, DONE
  } fsm_t;

  // Forward S-box, shared by the SubBytes and SubWord paths.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  fsm_t         fsm;
  logic [127:0] st;     // AES state
  logic [127:0] rk;     // current round key
  logic [3:0]   round;

  // SubBytes: byte position is irrelevant, so walk the word LSB-first.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = SBOX[s[8*i +: 8]];
    return o;
  endfunction

  // ShiftRows: new byte (r,c) takes old byte (r, c+r mod 4).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; row 0 is the top byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Next round key: SubWord(RotWord(w3)) ^ Rcon, then the XOR chain.
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    w0  = k[127:96];
    w1  = k[95:64];
    w2  = k[63:32];
    w3  = k[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {SBOX[rot[31:24]] ^ rc, SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Round sequencer: one AES transformation per clock, outputs registered.
  // NOTE: every register here uses <= so all state updates in a cycle see
  // the values from before the edge; mixing in = would reorder the round.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm   <= IDLE;
      st    <= '0;
      rk    <= '0;
      round <= '0;
      cifra <= '0;
      done  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            st    <= palavra;
            rk    <= chave;
            round <= '0;
            fsm   <= KEYEXP;
          end
        end
        // Round key 0 is the cipher key already held in rk.
        KEYEXP: fsm <= ARK0;
        ARK0: begin
          st    <= st ^ rk;
          round <= 4'd1;
          fsm   <= SB;
        end
        SB: begin
          st  <= sub_bytes(st);
          rk  <= next_key(rk, rcon(round));
          fsm <= SR;
        end
        SR: begin
          st  <= shift_rows(st);
          fsm <= (round == 4'd10) ? ARK : MC;
        end
        MC: begin
          st  <= mix_columns(st);
          fsm <= ARK;
        end
        ARK: begin
          st <= st ^ rk;
          if (round == 4'd10) begin
            fsm <= DONE;
          end else begin
            round <= round + 4'd1;
            fsm   <= SB;
          end
        end
        DONE: begin
          if (start) begin
            st    <= palavra;
            rk    <= chave;
            round <= '0;
            done  <= 1'b0;
            fsm   <= KEYEXP;
          end else begin
            cifra <= st;
            done  <= 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_criptografia.sv
// Self-checking bench for controlador_criptografia. A byte-array AES-128
// reference (S-box derived from the GF(2^8) inverse plus affine map) feeds
// a cycle-level expectation of done/cifra that is compared every cycle.
module tb_controlador_criptografia;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] chave = '0;
  logic [127:0] palavra = '0;
  logic [127:0] cifra;
  logic         done;

  int checks = 0;
  int failures = 0;

  controlador_criptografia dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .chave   (chave),
    .palavra (palavra),
    .cifra   (cifra),
    .done    (done)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference AES ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ 8'h63;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl8(r);
        s ^= r;
      end
      sbox[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] w [176];
    logic [7:0] tmp [4];
    logic [7:0] rc, x0;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      s[i] = pt[127-8*i -: 8];
      w[i] = key[127-8*i -: 8];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        x0 = tmp[0];
        tmp[0] = sbox[tmp[1]] ^ rc;
        tmp[1] = sbox[tmp[2]];
        tmp[2] = sbox[tmp[3]];
        tmp[3] = sbox[x0];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] ^= w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r2 = 0; r2 < 4; r2++) t[r2+4*c] = s[r2+4*((c+r2)%4)];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++)
          for (int r2 = 0; r2 < 4; r2++)
            s[r2+4*c] = gmul(t[4*c+r2], 8'h02) ^ gmul(t[4*c+(r2+1)%4], 8'h03)
                      ^ t[4*c+(r2+2)%4] ^ t[4*c+(r2+3)%4];
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- cycle-level expectation ----------------
  // A request is accepted when idle or once the run has reached DONE
  // (41 edges after its start edge); the result shows 42 edges after it.
  bit           m_run = 0;
  int           m_cnt = 0;
  logic [127:0] m_pend = '0;
  logic         exp_done = 1'b0;
  logic [127:0] exp_cifra = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0;
      m_cnt = 0;
      exp_done = 1'b0;
      exp_cifra = '0;
    end else if (start && (!m_run || m_cnt >= 41)) begin
      m_pend = aes_ref(palavra, chave);
      m_run = 1;
      m_cnt = 0;
      exp_done = 1'b0;
    end else if (m_run && m_cnt < 42) begin
      m_cnt++;
      if (m_cnt == 42) begin
        exp_done = 1'b1;
        exp_cifra = m_pend;
      end
    end
  end

  // Every-cycle comparison, half a period away from the active edge.
  always @(negedge clk) begin
    check("cyc_done", {127'b0, done}, {127'b0, exp_done});
    check("cyc_cifra", cifra, exp_cifra);
  end

  // ---------------- directed stimulus ----------------
  task automatic run_vec(input logic [127:0] pt, input logic [127:0] key,
                         input logic [127:0] expv, input int hold,
                         input bit scramble, input int pulse_at);
    int n;
    @(posedge clk);
    #2;
    palavra = pt;
    chave   = key;
    start   = 1'b1;
    @(posedge clk);                 // start edge
    n = 0;
    repeat (hold - 1) begin
      @(posedge clk);
      n++;
    end
    #2;
    start = 1'b0;
    check("done_low_after_start", {127'b0, done}, 128'd0);
    while (n < 100 && !done) begin
      @(posedge clk);
      n++;
      #1;
      if (scramble && n == 5) begin
        palavra = ~pt;
        chave   = ~key;
      end
      start = (pulse_at != 0 && n == pulse_at);
    end
    start = 1'b0;
    check("latency", 128'(n), 128'd42);
    check("result", cifra, expv);
  endtask

  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] CO = 128'h3f5b8cc9ea855a0afa7347d23e8d664e;
  localparam logic [127:0] P4 = 128'haabbccddeeff00112233445566778899;
  localparam logic [127:0] K4 = 128'h102030405060708090a0b0c0d0e0f000;
  localparam logic [127:0] C4 = 128'h2be52b98821c28a467897944fa4ac1bc;

  initial begin
    build_sbox();
    check("sbox_00", {120'b0, sbox[8'h00]}, 128'h63);
    check("sbox_53", {120'b0, sbox[8'h53]}, 128'hed);
    check("model_v1", aes_ref(P1, K1), C1);
    check("model_v2", aes_ref(P2, K2), C2);
    check("model_zero", aes_ref('0, '0), CZ);
    check("model_ones", aes_ref('1, '0), CO);
    check("model_v4", aes_ref(P4, K4), C4);

    repeat (3) @(posedge clk);
    check("reset_done", {127'b0, done}, 128'd0);
    check("reset_cifra", cifra, 128'd0);
    #2 rst = 1'b1;

    run_vec(P1, K1, C1, 1, 0, 0);
    run_vec(P2, K2, C2, 1, 0, 0);     // back-to-back from DONE
    run_vec('0, '0, CZ, 1, 0, 0);
    run_vec('1, '0, CO, 1, 0, 0);
    run_vec(P4, K4, C4, 1, 0, 0);

    // Abort around round 5.
    @(posedge clk);
    #2;
    palavra = P1;
    chave   = K1;
    start   = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_done", {127'b0, done}, 128'd0);
    check("abort_cifra", cifra, 128'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    run_vec(P2, K2, C2, 1, 0, 0);     // fresh start after reset
    run_vec(P4, K4, C4, 1, 1, 0);     // inputs change mid-run
    run_vec(P1, K1, C1, 2, 0, 0);     // start held two cycles
    run_vec('0, '0, CZ, 1, 0, 17);    // stray start mid-run ignored

    repeat (5) @(posedge clk);
    check("hold_done", {127'b0, done}, 128'd1);
    check("hold_cifra", cifra, CZ);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
